// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC register and req/resp instruction-fetch sequencer feeding decode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_fetch_en,
  input  logic [63:0]      i_next_pc,
  output logic [63:0]      o_current_pc,
  output logic             o_imem_req_valid,
  output logic [63:0]      o_imem_req_addr,
  input  logic             i_imem_req_ready,
  input  logic             i_imem_resp_valid,
  input  logic [31:0]      i_imem_resp_data,
  output logic             o_inst_valid,
  output logic [31:0]      o_inst,
  output logic [63:0]      o_inst_pc,
  input  logic             i_inst_ready,
  output logic             o_fetch_fault,
  output logic [CNT_W-1:0] o_retired_cnt
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [63:0]      r_pc;
  logic [31:0]      r_inst;
  logic             r_fault;
  logic [CNT_W-1:0] r_cnt;
  logic             w_req_valid;

  // Request follows fetch_en directly so a deasserted enable withdraws it in the same cycle.
  assign w_req_valid = rst_n && (r_state == S_REQ) && i_fetch_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_inst  <= 32'h0;
      r_fault <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_REQ: begin
          if (w_req_valid && i_imem_req_ready) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (i_imem_resp_valid) begin
            r_inst  <= i_imem_resp_data;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (i_inst_ready) begin
            r_pc  <= i_next_pc;
            r_cnt <= r_cnt + c_one;
            if (i_next_pc[1:0] == 2'b00) begin
              r_state <= S_REQ;
            end else begin
              r_state <= S_FAULT;
              r_fault <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_FAULT;
        end
      endcase
    end
  end

  assign o_current_pc     = r_pc;
  assign o_imem_req_valid = w_req_valid;
  assign o_imem_req_addr  = r_pc;
  assign o_inst_valid     = (r_state == S_HOLD);
  assign o_inst           = r_inst;
  assign o_inst_pc        = r_pc;
  assign o_fetch_fault    = r_fault;
  assign o_retired_cnt    = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed bench with a latency-programmable memory responder and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam logic [63:0] c_reset_pc = 64'h8000_0000;
  localparam int          c_cnt_w    = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               i_fetch_en;
  logic [63:0]        i_next_pc;
  logic [63:0]        o_current_pc;
  logic               o_imem_req_valid;
  logic [63:0]        o_imem_req_addr;
  logic               i_imem_req_ready;
  logic               i_imem_resp_valid = 1'b0;
  logic [31:0]        i_imem_resp_data  = 32'h0;
  logic               o_inst_valid;
  logic [31:0]        o_inst;
  logic [63:0]        o_inst_pc;
  logic               i_inst_ready;
  logic               o_fetch_fault;
  logic [c_cnt_w-1:0] o_retired_cnt;

  int          checks = 0;
  int          errors = 0;
  int          resp_delay = 0;
  logic [95:0] sb_q[$];
  logic [63:0] pc;

  fetch_unit #(.RESET_PC(c_reset_pc), .CNT_W(c_cnt_w)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_fetch_en        (i_fetch_en),
    .i_next_pc         (i_next_pc),
    .o_current_pc      (o_current_pc),
    .o_imem_req_valid  (o_imem_req_valid),
    .o_imem_req_addr   (o_imem_req_addr),
    .i_imem_req_ready  (i_imem_req_ready),
    .i_imem_resp_valid (i_imem_resp_valid),
    .i_imem_resp_data  (i_imem_resp_data),
    .o_inst_valid      (o_inst_valid),
    .o_inst            (o_inst),
    .o_inst_pc         (o_inst_pc),
    .i_inst_ready      (i_inst_ready),
    .o_fetch_fault     (o_fetch_fault),
    .o_retired_cnt     (o_retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h8000_0013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory model: answers each accepted request resp_delay cycles after the accept cycle.
  initial begin : responder
    int          cnt;
    logic [63:0] addr;
    logic [63:0] addr_s;
    logic        acc;
    cnt  = 0;
    addr = 64'h0;
    forever begin
      @(posedge clk);
      acc    = o_imem_req_valid && i_imem_req_ready;
      addr_s = o_imem_req_addr;
      #1;
      i_imem_resp_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          i_imem_resp_valid = 1'b1;
          i_imem_resp_data  = mem_word(addr);
        end
      end
      if (acc) begin
        addr = addr_s;
        if (resp_delay == 0) begin
          i_imem_resp_valid = 1'b1;
          i_imem_resp_data  = mem_word(addr);
        end else begin
          cnt = resp_delay;
        end
      end
    end
  end

  initial begin : sb_check
    logic        prev;
    logic [95:0] e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (o_inst_valid && !prev) begin
        chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("sb_inst", 64'(o_inst), 64'(e[31:0]));
          chk("sb_inst_pc", o_inst_pc, e[95:32]);
        end
      end
      prev = o_inst_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_hold(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!o_inst_valid) chk({tag, "_timeout"}, 64'(o_inst_valid), 64'd1);
  endtask

  task automatic consume(input logic [63:0] npc);
    i_next_pc    = npc;
    i_inst_ready = 1'b1;
    @(posedge clk);
    #1;
    i_inst_ready = 1'b0;
    if (npc[1:0] == 2'b00) sb_q.push_back({npc, mem_word(npc)});
  endtask

  initial begin : main
    rst_n            = 1'b0;
    i_fetch_en       = 1'b1;
    i_imem_req_ready = 1'b1;
    i_inst_ready     = 1'b0;
    i_next_pc        = 64'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc", o_current_pc, c_reset_pc);
    chk("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(o_inst_valid), 64'd0);
    chk("rst_inst", 64'(o_inst), 64'd0);
    chk("rst_fault", 64'(o_fetch_fault), 64'd0);
    chk("rst_cnt", 64'(o_retired_cnt), 64'd0);

    // Zero-wait fetch right after reset release
    sb_q.push_back({c_reset_pc, mem_word(c_reset_pc)});
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t1_req_valid", 64'(o_imem_req_valid), 64'd1);
    chk("t1_req_addr", o_imem_req_addr, c_reset_pc);
    @(negedge clk);
    chk("t1_wait_inst_valid", 64'(o_inst_valid), 64'd0);
    chk("t1_wait_req_valid", 64'(o_imem_req_valid), 64'd0);
    @(negedge clk);
    chk("t1_inst_valid", 64'(o_inst_valid), 64'd1);
    chk("t1_inst", 64'(o_inst), 64'h13);
    chk("t1_inst_pc", o_inst_pc, c_reset_pc);

    // Sequential consumes
    pc = 64'h8000_0004;
    consume(pc);
    @(negedge clk);
    chk("t2_pc", o_current_pc, 64'h8000_0004);
    chk("t2_req_valid", 64'(o_imem_req_valid), 64'd1);
    chk("t2_req_addr", o_imem_req_addr, 64'h8000_0004);
    chk("t2_cnt1", 64'(o_retired_cnt), 64'd1);
    for (int k = 0; k < 9; k++) begin
      wait_hold("t2");
      pc = pc + 64'd4;
      consume(pc);
    end
    @(negedge clk);
    chk("t2_cnt10", 64'(o_retired_cnt), 64'd10);
    chk("t2_pc_final", o_current_pc, pc);

    // Back-pressure, withdrawn requests and stray inst_ready
    i_imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_req_valid", 64'(o_imem_req_valid), 64'd1);
      chk("t3_stall_addr", o_imem_req_addr, pc);
    end
    i_next_pc    = 64'hDEAD_BEE0;
    i_inst_ready = 1'b1;
    @(negedge clk);
    i_inst_ready = 1'b0;
    chk("t3_ignore_pc", o_current_pc, pc);
    chk("t3_ignore_cnt", 64'(o_retired_cnt), 64'd10);
    i_fetch_en = 1'b0;
    @(negedge clk);
    chk("t3_en0_req_valid", 64'(o_imem_req_valid), 64'd0);
    i_imem_req_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t3_en0_req_valid", 64'(o_imem_req_valid), 64'd0);
      chk("t3_en0_pc", o_current_pc, pc);
      chk("t3_en0_inst_valid", 64'(o_inst_valid), 64'd0);
    end
    resp_delay = 2;
    i_fetch_en = 1'b1;
    @(posedge clk);
    #1 i_fetch_en = 1'b0;
    wait_hold("t3_accepted_completes");
    resp_delay = 0;
    i_fetch_en = 1'b1;

    // Decode stall in S_HOLD
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_valid", 64'(o_inst_valid), 64'd1);
      chk("t4_inst", 64'(o_inst), 64'(mem_word(pc)));
      chk("t4_inst_pc", o_inst_pc, pc);
      chk("t4_cnt", 64'(o_retired_cnt), 64'd10);
    end
    pc = pc + 64'd4;
    consume(pc);
    @(negedge clk);
    chk("t4_cnt_after", 64'(o_retired_cnt), 64'd11);
    chk("t4_pc_after", o_current_pc, pc);

    // Misaligned target fault
    wait_hold("t5");
    consume(64'h8000_0006);
    repeat (4) begin
      @(negedge clk);
      chk("t5_fault", 64'(o_fetch_fault), 64'd1);
      chk("t5_req_valid", 64'(o_imem_req_valid), 64'd0);
      chk("t5_inst_valid", 64'(o_inst_valid), 64'd0);
      chk("t5_pc", o_current_pc, 64'h8000_0006);
    end
    chk("t5_cnt", 64'(o_retired_cnt), 64'd12);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_pc", o_current_pc, c_reset_pc);
    chk("t5_rst_fault", 64'(o_fetch_fault), 64'd0);
    chk("t5_rst_cnt", 64'(o_retired_cnt), 64'd0);

    // Reset mid-S_WAIT; the late response must be discarded
    resp_delay = 3;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_wait_req_valid", 64'(o_imem_req_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n            = 1'b0;
    i_imem_req_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_stale_inst_valid", 64'(o_inst_valid), 64'd0);
    chk("t6_stale_req_valid", 64'(o_imem_req_valid), 64'd1);
    chk("t6_stale_req_addr", o_imem_req_addr, c_reset_pc);
    chk("t6_stale_pc", o_current_pc, c_reset_pc);
    resp_delay = 0;
    pc = c_reset_pc;
    sb_q.push_back({pc, mem_word(pc)});
    i_imem_req_ready = 1'b1;
    wait_hold("t6_fresh");

    // Counter wrap at 2^CNT_W
    for (int k = 0; k < 15; k++) begin
      pc = pc + 64'd4;
      consume(pc);
      wait_hold("t6_wrap");
    end
    chk("t6_cnt_max", 64'(o_retired_cnt), 64'd15);
    pc = pc + 64'd4;
    consume(pc);
    @(negedge clk);
    chk("t6_cnt_wrap", 64'(o_retired_cnt), 64'd0);
    chk("t6_pc_wrap", o_current_pc, pc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
